// File: rtl/add_pkg.sv
// Shared types and widths for the 4-bit adder responder.
package add_pkg;

  localparam int ADD_W = 4;
  localparam int SUM_W = ADD_W + 1;

  typedef logic [SUM_W-1:0] sum_t;

  typedef struct packed {
    logic             carry;
    logic [ADD_W-1:0] sum_lo;
  } add_rsp_t;

endpackage

// File: rtl/add_rsp_fifo.sv
// Generic synchronous FIFO with an occupancy counter, asynchronous active-low
// reset and synchronous flush. The read data is the head entry, so it is
// stable until that entry is popped.
module add_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          full_s;
  logic          empty_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_s    = (level_r == (AW+1)'(DEPTH));
  assign empty_s   = (level_r == (AW+1)'(0));
  assign push_ok_s = push && !full_s && !flush;
  assign pop_ok_s  = pop && !empty_s && !flush;

  // Pointer and occupancy bookkeeping; flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage; cleared on reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign level = level_r;

endmodule

// File: rtl/add_rsp_unit.sv
// Responder for the adder operand interface: accepts (a, b) pairs, queues the
// full-width sum and returns it over a valid/ready handshake, counting pops.
module add_rsp_unit
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH:0]           out_sum,
  output logic                     out_carry,
  output logic [CNT_W-1:0]         txn_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   head_s;
  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic [CNT_W-1:0] txn_cnt_r;

  // Sum at WIDTH+1 bits so the carry is never truncated.
  assign sum_s = {1'b0, in_a} + {1'b0, in_b};

  add_rsp_fifo #(
    .DEPTH (DEPTH),
    .DW    (WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (in_valid),
    .wdata (sum_s),
    .pop   (out_ready),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level)
  );

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign out_sum   = head_s;
  assign out_carry = head_s[WIDTH];

  // A pop coinciding with a flush is discarded and does not count.
  assign pop_s = out_valid && out_ready && !flush;

  // Completed-transaction counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt_r <= '0;
    end else if (pop_s && (txn_cnt_r != {CNT_W{1'b1}})) begin
      txn_cnt_r <= txn_cnt_r + CNT_W'(1);
    end
  end

  assign txn_cnt = txn_cnt_r;

endmodule

// File: tb/tb_add_rsp_unit.sv
// Self-checking bench for add_rsp_unit: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_add_rsp_unit;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH:0]   out_sum;
  logic             out_carry;
  logic [CNT_W-1:0] txn_cnt;
  logic [LW-1:0]    level;

  int q[$];
  int cnt_m = 0;
  int checks = 0;
  int errors = 0;
  int saved_cnt;

  add_rsp_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .txn_cnt   (txn_cnt),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_state();
    check("level", 32'(level), q.size());
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("txn_cnt", 32'(txn_cnt), cnt_m);
    if (q.size() > 0) begin
      check("out_sum", 32'(out_sum), q[0]);
      check("out_carry", 32'(out_carry), q[0] >> WIDTH);
    end
  endtask

  task automatic drive(input bit v, input int a, input int b, input bit r, input bit f);
    in_valid  = v;
    in_a      = a[WIDTH-1:0];
    in_b      = b[WIDTH-1:0];
    out_ready = r;
    flush     = f;
  endtask

  // Check current outputs, then advance one clock and update the model.
  task automatic cycle();
    bit do_push;
    bit do_pop;
    int s;
    compare_state();
    do_pop  = !flush && out_ready && (q.size() > 0);
    do_push = !flush && in_valid && (q.size() < DEPTH);
    s = int'(in_a) + int'(in_b);
    @(posedge clk);
    if (flush) q.delete();
    if (do_pop) begin
      void'(q.pop_front());
      if (cnt_m < CMAX) cnt_m++;
    end
    if (do_push) q.push_back(s);
    #1;
  endtask

  initial begin
    // Reset
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    compare_state();
    check("rst_sum", 32'(out_sum), 0);
    check("rst_carry", 32'(out_carry), 0);

    // 1: single operation
    drive(1, 4, 4, 1, 0); cycle();
    check("t1_valid", 32'(out_valid), 1);
    check("t1_sum", 32'(out_sum), 8);
    check("t1_carry", 32'(out_carry), 0);
    drive(0, 0, 0, 1, 0); cycle();
    check("t1_txn", 32'(txn_cnt), 1);

    // 2: back-to-back stream
    drive(1, 3, 4, 1, 0); cycle();
    check("t2_sum0", 32'(out_sum), 7);
    drive(1, 3, 7, 1, 0); cycle();
    check("t2_sum1", 32'(out_sum), 10);
    check("t2_lvl", 32'(level), 1);
    drive(1, 15, 15, 1, 0); cycle();
    check("t2_sum2", 32'(out_sum), 30);
    check("t2_carry", 32'(out_carry), 1);
    drive(0, 0, 0, 1, 0); cycle();
    cycle();

    // 3: backpressure
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, i, 0, 0); cycle();
    end
    check("t3_lvl", 32'(level), 4);
    check("t3_rdy", 32'(in_ready), 0);
    check("t3_hold", 32'(out_sum), 2);
    drive(1, 9, 9, 0, 0); cycle();
    check("t3_lvl5", 32'(level), 4);
    check("t3_hold5", 32'(out_sum), 2);
    drive(0, 0, 0, 1, 0); cycle();
    check("t3_rdy_back", 32'(in_ready), 1);
    check("t3_next", 32'(out_sum), 4);
    for (int i = 0; i < 4; i++) cycle();

    // 4: simultaneous push/pop at level 2
    drive(1, 6, 1, 0, 0); cycle();
    drive(1, 2, 9, 0, 0); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom_range(0, 15), $urandom_range(0, 15), 1, 0); cycle();
      check("t4_lvl", 32'(level), 2);
    end
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle();

    // 5: flush at level 3 with a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1, i + 1, 2, 0, 0); cycle();
    end
    check("t5_lvl3", 32'(level), 3);
    saved_cnt = int'(txn_cnt);
    drive(1, 5, 5, 1, 1); cycle();
    check("t5_lvl0", 32'(level), 0);
    check("t5_valid", 32'(out_valid), 0);
    check("t5_txn", 32'(txn_cnt), saved_cnt);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle();

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 1), ($urandom_range(0, 15) == 0));
      cycle();
    end

    // 6: asynchronous reset at level 2
    drive(0, 0, 0, 0, 1); cycle();
    drive(1, 12, 13, 0, 0); cycle();
    drive(1, 9, 9, 0, 0); cycle();
    check("t6_lvl2", 32'(level), 2);
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    cnt_m = 0;
    check("t6_valid", 32'(out_valid), 0);
    check("t6_level", 32'(level), 0);
    check("t6_sum", 32'(out_sum), 0);
    check("t6_carry", 32'(out_carry), 0);
    check("t6_txn", 32'(txn_cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("t6_rdy", 32'(in_ready), 1);
    @(posedge clk); #1;
    compare_state();

    // Saturation of txn_cnt
    for (int i = 0; i < 270; i++) begin
      drive(1, $urandom_range(0, 15), $urandom_range(0, 15), 1, 0); cycle();
    end
    check("sat_255", 32'(txn_cnt), 255);
    for (int i = 0; i < 5; i++) cycle();
    check("sat_hold", 32'(txn_cnt), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
